// File: rtl/vdp_pkg.sv
// Shared types for the video line-buffer controller: address/colour widths and
// the draw-side state encoding.
package vdp_pkg;
  localparam int LB_LINE_WORDS = 80;

  typedef logic [8:0] colour_t;
  typedef logic [8:0] lb_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_DONE
  } draw_state_t;
endpackage

// File: rtl/lb_clear_seq.sv
// Walks the on-screen buffer from word 0 to LINE_WORDS-1, one word per cycle,
// after every start pulse; a new start restarts the walk from 0.
module lb_clear_seq
  import vdp_pkg::*;
#(
  parameter int LINE_WORDS = LB_LINE_WORDS
) (
  input  logic     clk_draw,
  input  logic     rst_draw,
  input  logic     start,
  output lb_addr_t addr,
  output logic     we,
  output logic     clearing
);
  logic last;
  assign last = (addr == lb_addr_t'(LINE_WORDS - 1));

  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      addr     <= '0;
      we       <= 1'b0;
      clearing <= 1'b0;
    end else if (start) begin
      addr     <= '0;
      we       <= 1'b1;
      clearing <= 1'b1;
    end else if (we) begin
      if (last) begin
        addr     <= '0;
        we       <= 1'b0;
        clearing <= 1'b0;
      end else begin
        addr <= addr + lb_addr_t'(1);
      end
    end
  end
endmodule

// File: rtl/linebuffer_ctrl.sv
// Double-buffered scanline controller: flips buffers on line_start, clears the
// newly displayed buffer and forwards renderer writes into the hidden one.
module linebuffer_ctrl
  import vdp_pkg::*;
#(
  parameter int      LINE_WORDS   = LB_LINE_WORDS,
  parameter colour_t CLEAR_COLOUR = 9'h000
) (
  input  logic        clk_draw,
  input  logic        rst_draw,
  input  logic        line_start,
  input  logic        draw_valid,
  input  logic [8:0]  draw_addr,
  input  logic [7:0]  draw_we,
  input  logic [71:0] draw_colour,
  input  logic        draw_last,
  output logic        draw_ready,
  output logic        line_req,
  output logic        buffsel_draw,
  output logic [8:0]  addr_on_draw,
  output logic        we_on_draw,
  output logic [71:0] colour_on_draw,
  output logic [8:0]  addr_off_draw,
  output logic [7:0]  we_off_draw,
  output logic [71:0] colour_off_draw,
  output logic        clearing,
  output logic [7:0]  overrun_count,
  output logic        addr_err
);
  draw_state_t state, state_next;
  logic        ready_next;
  logic        accept;
  logic        addr_ok;
  logic        overrun_hit;

  assign accept  = draw_valid && draw_ready;
  assign addr_ok = (draw_addr < lb_addr_t'(LINE_WORDS));

  always_comb begin
    state_next  = state;
    overrun_hit = 1'b0;
    if (line_start) begin
      state_next  = ST_DRAW;
      // A flip that interrupts either an unfinished line or a running clear
      // counts once, however many of the two it interrupts.
      overrun_hit = (state == ST_DRAW) || we_on_draw;
    end else begin
      case (state)
        ST_DRAW: if (accept && draw_last) state_next = ST_DONE;
        default: state_next = state;
      endcase
    end
    // Hold ready low during the line_req cycle so the renderer sees a clean start.
    ready_next = (state_next == ST_DRAW) && !line_start;
  end

  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      state        <= ST_IDLE;
      draw_ready   <= 1'b0;
      line_req     <= 1'b0;
      buffsel_draw <= 1'b0;
    end else begin
      state        <= state_next;
      draw_ready   <= ready_next;
      line_req     <= line_start;
      buffsel_draw <= buffsel_draw ^ line_start;
    end
  end

  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      we_off_draw     <= '0;
      addr_off_draw   <= '0;
      colour_off_draw <= '0;
      addr_err        <= 1'b0;
      overrun_count   <= '0;
    end else begin
      we_off_draw <= (accept && addr_ok) ? draw_we : 8'h00;
      if (accept) begin
        addr_off_draw   <= draw_addr;
        colour_off_draw <= draw_colour;
      end
      if (accept && !addr_ok) addr_err <= 1'b1;
      if (overrun_hit && (overrun_count != 8'hFF)) overrun_count <= overrun_count + 8'd1;
    end
  end

  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) colour_on_draw <= {8{CLEAR_COLOUR}};
    else          colour_on_draw <= {8{CLEAR_COLOUR}};
  end

  lb_clear_seq #(
    .LINE_WORDS(LINE_WORDS)
  ) u_clear (
    .clk_draw (clk_draw),
    .rst_draw (rst_draw),
    .start    (line_start),
    .addr     (addr_on_draw),
    .we       (we_on_draw),
    .clearing (clearing)
  );
endmodule

// File: tb/tb_linebuffer_ctrl.sv
// Directed bench for linebuffer_ctrl: a cycle-level behavioural model checked
// every cycle, plus hand-computed literal checks at key points.
module tb_linebuffer_ctrl;
  localparam int         LW = 80;
  localparam logic [8:0] CC = 9'h1A5;

  logic        clk_draw = 1'b0, rst_draw = 1'b0, line_start = 1'b0;
  logic        draw_valid = 1'b0, draw_last = 1'b0;
  logic [8:0]  draw_addr = '0;
  logic [7:0]  draw_we = '0;
  logic [71:0] draw_colour = '0;
  logic        draw_ready, line_req, buffsel_draw, we_on_draw, clearing, addr_err;
  logic [8:0]  addr_on_draw, addr_off_draw;
  logic [7:0]  we_off_draw, overrun_count;
  logic [71:0] colour_on_draw, colour_off_draw;

  int passed = 0, total = 0;

  linebuffer_ctrl #(.LINE_WORDS(LW), .CLEAR_COLOUR(CC)) dut (
    .clk_draw(clk_draw), .rst_draw(rst_draw), .line_start(line_start),
    .draw_valid(draw_valid), .draw_addr(draw_addr), .draw_we(draw_we),
    .draw_colour(draw_colour), .draw_last(draw_last), .draw_ready(draw_ready),
    .line_req(line_req), .buffsel_draw(buffsel_draw), .addr_on_draw(addr_on_draw),
    .we_on_draw(we_on_draw), .colour_on_draw(colour_on_draw),
    .addr_off_draw(addr_off_draw), .we_off_draw(we_off_draw),
    .colour_off_draw(colour_off_draw), .clearing(clearing),
    .overrun_count(overrun_count), .addr_err(addr_err)
  );

  always #5 clk_draw = ~clk_draw;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: what the outputs must be, from the rules (line open/closed,
  // cycles since the last flip, last accepted beat).
  bit          m_buffsel, m_line_req, m_ready, m_in_line, m_err;
  int          m_clr, m_ovr;
  logic [7:0]  m_we_off;
  logic [8:0]  m_addr_off;
  logic [71:0] m_col_off;

  always @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      m_buffsel = 0; m_line_req = 0; m_ready = 0; m_in_line = 0; m_err = 0;
      m_clr = -1; m_ovr = 0; m_we_off = 0; m_addr_off = 0; m_col_off = 0;
    end else begin
      bit acc, bad, busy;
      acc  = draw_valid && m_ready;
      bad  = acc && (int'(draw_addr) >= LW);
      busy = (m_clr >= 0);
      m_we_off = (acc && !bad) ? draw_we : 8'h00;
      if (acc) begin m_addr_off = draw_addr; m_col_off = draw_colour; end
      if (bad) m_err = 1;
      if (line_start) begin
        if ((m_in_line || busy) && m_ovr < 255) m_ovr++;
        m_buffsel  = !m_buffsel;
        m_line_req = 1;
        m_in_line  = 1;
        m_ready    = 0;
        m_clr      = 0;
      end else begin
        m_line_req = 0;
        if (acc && draw_last) m_in_line = 0;
        m_ready = m_in_line;
        if (busy) m_clr = (m_clr == LW - 1) ? -1 : m_clr + 1;
      end
    end
  end

  always @(negedge clk_draw) begin
    chk("line_req", line_req, m_line_req);
    chk("buffsel", buffsel_draw, m_buffsel);
    chk("draw_ready", draw_ready, m_ready);
    chk("we_on", we_on_draw, m_clr >= 0);
    chk("clearing", clearing, m_clr >= 0);
    if (m_clr >= 0) chk("addr_on", addr_on_draw, m_clr);
    chk("we_off", we_off_draw, m_we_off);
    if (m_we_off != 0) begin
      chk("addr_off", addr_off_draw, m_addr_off);
      chk("colour_off", colour_off_draw, m_col_off);
    end
    chk("overrun", overrun_count, m_ovr);
    chk("addr_err", addr_err, m_err);
    chk("colour_on", colour_on_draw, {8{CC}});
  end

  task automatic pulse_ls();
    @(negedge clk_draw); line_start = 1;
    @(negedge clk_draw); line_start = 0;
  endtask

  task automatic beat(input logic [8:0] a, input logic [7:0] w, input logic [71:0] c, input logic l);
    draw_valid = 1; draw_addr = a; draw_we = w; draw_colour = c; draw_last = l;
  endtask

  initial begin
    int n, wr;
    #1 rst_draw = 1;
    repeat (3) @(negedge clk_draw);
    chk("rst_we_on", we_on_draw, 0);
    chk("rst_ready", draw_ready, 0);
    chk("rst_buffsel", buffsel_draw, 0);
    rst_draw = 0;
    repeat (2) @(negedge clk_draw);

    // first flip: full clear, with three beats and a stalled request alongside
    pulse_ls();
    chk("first_line_req", line_req, 1);
    chk("first_buffsel", buffsel_draw, 1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (we_on_draw) begin chk("clr_seq", addr_on_draw, n); n++; end
      if (i == 11) begin chk("beat5_we", we_off_draw, 8'hFF); chk("beat5_addr", addr_off_draw, 5); end
      if (i == 12) begin chk("beat6_we", we_off_draw, 8'h0F); chk("beat6_addr", addr_off_draw, 6); end
      if (i == 13) begin chk("beat7_addr", addr_off_draw, 7); chk("done_ready", draw_ready, 0); end
      if (i == 18) chk("stall_no_write", we_off_draw, 0);
      case (i)
        10: beat(9'd5, 8'hFF, {8{9'h011}}, 0);
        11: beat(9'd6, 8'h0F, {8{9'h022}}, 0);
        12: beat(9'd7, 8'hF0, {8{9'h033}}, 1);
        13: beat(9'd9, 8'hAA, {8{9'h044}}, 0);
        20: draw_valid = 0;
        default: ;
      endcase
      @(negedge clk_draw);
    end
    chk("clr_count", n, 80);

    // overrun: flip mid-line at clear address 40, then saturate
    pulse_ls();
    repeat (40) @(negedge clk_draw);
    chk("clr_at_40", addr_on_draw, 40);
    line_start = 1;
    @(negedge clk_draw); line_start = 0;
    chk("ovr_one", overrun_count, 1);
    chk("ovr_restart", addr_on_draw, 0);
    chk("ovr_buffsel", buffsel_draw, 1);
    line_start = 1;
    repeat (300) @(negedge clk_draw);
    line_start = 0;
    chk("ovr_sat", overrun_count, 255);

    // out-of-range beat then a valid last beat
    @(negedge clk_draw); beat(9'd80, 8'hFF, {8{9'h155}}, 0);
    @(negedge clk_draw);
    chk("err_no_write", we_off_draw, 0);
    chk("err_set", addr_err, 1);
    beat(9'd10, 8'h3C, {8{9'h0AA}}, 1);
    @(negedge clk_draw); draw_valid = 0;
    chk("after_err_addr", addr_off_draw, 10);
    repeat (5) @(negedge clk_draw);
    chk("err_sticky", addr_err, 1);

    // reset in the middle of a clear
    pulse_ls();
    repeat (20) @(negedge clk_draw);
    chk("clr_at_20", addr_on_draw, 20);
    #2 rst_draw = 1;
    #1;
    chk("rst_mid_we_on", we_on_draw, 0);
    chk("rst_mid_we_off", we_off_draw, 0);
    chk("rst_mid_err", addr_err, 0);
    chk("rst_mid_ovr", overrun_count, 0);
    repeat (2) @(negedge clk_draw);
    #2 rst_draw = 0;
    beat(9'd3, 8'hFF, {8{9'h077}}, 0);
    wr = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_draw);
      if (we_on_draw || we_off_draw != 0) wr++;
    end
    chk("no_wr_after_rst", wr, 0);
    draw_valid = 0;
    pulse_ls();
    chk("post_rst_clear", we_on_draw, 1);
    repeat (90) @(negedge clk_draw);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/linebuffer_ctrl.md
LINEBUFFER_CTRL -- requirements
Module: linebuffer_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 80, meaning the number of 8-pixel words per scanline (640/8).
REQ-002 SHALL have parameter CLEAR_COLOUR, default 9'h000, meaning the colour written to every pixel during on-screen clear.
REQ-003 SHALL have port clk_draw, input, width 1, the single clock (draw domain).
REQ-004 SHALL have port rst_draw, input, width 1; reset is asynchronous and active-high.
REQ-005 SHALL have port line_start, input, width 1, a one-cycle pulse already synchronised to clk_draw that requests a buffer flip.
REQ-006 SHALL have draw request inputs: draw_valid (1), draw_addr (9), draw_we (8), draw_colour (72), draw_last (1, marks the final write of the line).
REQ-007 SHALL have port draw_ready, output, width 1, the draw handshake ready.
REQ-008 SHALL have port line_req, output, width 1, a one-cycle pulse telling the renderer to begin the next line.
REQ-009 SHALL have port buffsel_draw, output, width 1, the draw-domain buffer select.
REQ-010 SHALL have clear port outputs addr_on_draw (9), we_on_draw (1) and colour_on_draw (72).
REQ-011 SHALL have off-screen write outputs addr_off_draw (9), we_off_draw (8) and colour_off_draw (72).
REQ-012 SHALL have status outputs clearing (1), overrun_count (8) and addr_err (1, sticky).

Function
REQ-013 SHALL implement draw FSM states IDLE, DRAW and DONE.
REQ-014 IDLE and DONE SHALL go to DRAW on line_start; DRAW SHALL go to DONE on an accepted beat (draw_valid && draw_ready) with draw_last=1.
REQ-015 Any state sampling line_start SHALL, at the next edge, toggle buffsel_draw, pulse line_req for one cycle and enter DRAW.
REQ-016 line_start sampled in DRAW SHALL increment overrun_count, saturating at 255; the abandoned line is not completed.
REQ-017 draw_ready SHALL equal 1 only in DRAW, and SHALL be 0 in the cycle line_req is asserted.
REQ-018 An accepted beat SHALL appear on the off port one cycle later, with addr_off_draw=draw_addr, we_off_draw=draw_we and colour_off_draw=draw_colour.
REQ-019 In every cycle without an accepted beat, we_off_draw SHALL be 8'h00.
REQ-020 An accepted beat with draw_addr >= LINE_WORDS SHALL produce we_off_draw=0 and set addr_err; it is still consumed, and draw_last still applies.
REQ-021 The cycle after each flip, the clear sequencer SHALL drive addr_on_draw=0 and we_on_draw=1, incrementing by 1 per cycle through LINE_WORDS-1, then we_on_draw=0.
REQ-022 colour_on_draw SHALL be {8{CLEAR_COLOUR}} constantly.
REQ-023 clearing SHALL be 1 exactly while we_on_draw=1.
REQ-024 line_start during a clear SHALL restart the clear at address 0 after the flip, and SHALL increment overrun_count unless the increment is already counted under REQ-016 (one increment max per line_start).
REQ-025 Clear and off-screen writes SHALL proceed concurrently (separate ports); no arbitration stalls between them.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 rst_draw SHALL asynchronously force: state=IDLE, buffsel_draw=0, line_req=0, draw_ready=0, we_on_draw=0, we_off_draw=0, addr_on_draw=0, addr_off_draw=0, colour_off_draw=0, clearing=0, overrun_count=0, addr_err=0.
REQ-028 Reset asserted mid-clear or mid-line SHALL abort the operation; after release, no write occurs until the next line_start.

Structure
REQ-029 Package vdp_pkg SHALL hold the LINE_WORDS default, the colour_t (9-bit) typedef, the lb_addr_t (9-bit) typedef and the draw-FSM state enum.
REQ-030 The clear address counter plus we/clearing generation SHALL be sub-module lb_clear_seq (inputs: start, clk_draw, rst_draw).

Verification
REQ-031 Reset, then a single line_start -> buffsel_draw=1, line_req pulse, then we_on_draw=1 for exactly 80 cycles, addr 0..79.
REQ-032 In DRAW, 3 beats at addr 5,6,7 with the last beat having draw_last -> we_off_draw matches each beat 1 cycle later; state=DONE; draw_ready=0.
REQ-033 draw_valid held with draw_ready low (IDLE/DONE) -> we_off_draw stays 0.
REQ-034 line_start while in DRAW at clear addr 40 -> buffsel toggles, clear restarts at 0, overrun_count=1; 300 overruns -> count 255.
REQ-035 Beat at draw_addr=80 -> no write, addr_err=1 and held until reset.
REQ-036 rst_draw asserted mid-clear at addr 20 -> all we outputs 0 immediately; no writes after release until line_start.
